// File: rtl/mem_responder.sv
// Synthesizable memory-side bus responder: tagged loads returned after a fixed latency,
// stores written immediately, 64-bit word backing store.
module mem_responder #(
    parameter int unsigned MEM_LATENCY_CYCLES = 4,
    parameter int unsigned NUM_TAGS           = 15,
    parameter int unsigned MEM_DEPTH_WORDS    = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag,
    output logic [4:0]  mem_outstanding
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    localparam int unsigned IDX_W      = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH_WORDS) << 3;

    logic [63:0]         mem [MEM_DEPTH_WORDS];
    logic [3:0]          pipe_tag  [MEM_LATENCY_CYCLES];
    logic [63:0]         pipe_data [MEM_LATENCY_CYCLES];
    logic [NUM_TAGS-1:0] busy;
    logic [NUM_TAGS-1:0] busy_next;
    logic [3:0]          free_tag;
    logic                tag_avail;
    logic                in_range;
    logic                load_accept;
    logic                store_accept;
    logic [3:0]          ret_tag;
    logic [IDX_W-1:0]    word_idx;

    assign word_idx     = proc2mem_addr[IDX_W+2:3];
    assign in_range     = {1'b0, proc2mem_addr} < ADDR_LIMIT;
    assign load_accept  = !reset && (proc2mem_command == BUS_LOAD) && in_range && tag_avail;
    assign store_accept = !reset && (proc2mem_command == BUS_STORE) && in_range;
    assign ret_tag      = pipe_tag[MEM_LATENCY_CYCLES-1];

    assign mem2proc_tag  = ret_tag;
    assign mem2proc_data = pipe_data[MEM_LATENCY_CYCLES-1];

    always_comb begin
        free_tag  = '0;
        tag_avail = 1'b0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (!tag_avail && !busy[t]) begin
                free_tag  = 4'(t + 1);
                tag_avail = 1'b1;
            end
        end
    end

    always_comb begin
        mem2proc_response = '0;
        if (load_accept) begin
            mem2proc_response = free_tag;
        end else if (store_accept) begin
            mem2proc_response = tag_avail ? free_tag : 4'd1;
        end
    end

    // A returning tag stays busy through its return cycle, so it can never be the one allocated here.
    always_comb begin
        busy_next = busy;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (ret_tag == 4'(t + 1)) begin
                busy_next[t] = 1'b0;
            end
            if (load_accept && free_tag == 4'(t + 1)) begin
                busy_next[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (store_accept) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    // Delay line: an entry enters at the acceptance edge and is visible on the outputs
    // exactly MEM_LATENCY_CYCLES cycles after the acceptance cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_LATENCY_CYCLES; i++) begin
                pipe_tag[i]  <= '0;
                pipe_data[i] <= '0;
            end
            busy            <= '0;
            mem_outstanding <= '0;
        end else begin
            pipe_tag[0]  <= load_accept ? free_tag : '0;
            pipe_data[0] <= load_accept ? mem[word_idx] : '0;
            for (int unsigned i = 1; i < MEM_LATENCY_CYCLES; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            busy            <= busy_next;
            mem_outstanding <= mem_outstanding + 5'(load_accept) - 5'(ret_tag != '0);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic checked every cycle
// against a cycle-indexed schedule model of tags, returns and storage.
module tb_mem_responder;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = '0;
    logic [31:0] addr  = '0;
    logic [63:0] wdata = '0;

    logic [3:0]  resp_a, tag_a, resp_b, tag_b;
    logic [63:0] data_a, data_b;
    logic [4:0]  outs_a, outs_b;

    mem_responder #(.MEM_LATENCY_CYCLES(LAT), .NUM_TAGS(15), .MEM_DEPTH_WORDS(DEPTH)) dut (
        .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdata), .mem2proc_response(resp_a), .mem2proc_data(data_a),
        .mem2proc_tag(tag_a), .mem_outstanding(outs_a)
    );

    mem_responder #(.MEM_LATENCY_CYCLES(LAT), .NUM_TAGS(2), .MEM_DEPTH_WORDS(DEPTH)) dut_small (
        .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdata), .mem2proc_response(resp_b), .mem2proc_data(data_b),
        .mem2proc_tag(tag_b), .mem_outstanding(outs_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int num_tags = 15;
    bit use_small = 1'b0;

    // Tag t is busy from the cycle after acceptance up to and including its return cycle.
    int free_from [16];
    int accept_at [16];
    logic [3:0]  ret_tag_at   [int];
    logic [63:0] ret_data_at  [int];
    bit          ret_known_at [int];
    logic [63:0] model_mem    [int unsigned];

    logic [31:0] word_addr [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < 16; t++) begin
            free_from[t] = 0;
            accept_at[t] = 0;
        end
        ret_tag_at.delete();
        ret_data_at.delete();
        ret_known_at.delete();
    endfunction

    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d, input bit rst);
        logic [3:0]  e_resp, e_tag, lowest, a_resp, a_tag;
        logic [63:0] e_data, a_data;
        logic [4:0]  a_outs;
        int          e_outs;
        bit          known, in_range, wk;
        @(negedge clock);
        reset = rst;
        cmd   = c;
        addr  = a;
        wdata = d;
        #1;
        a_resp = use_small ? resp_b : resp_a;
        a_tag  = use_small ? tag_b  : tag_a;
        a_data = use_small ? data_b : data_a;
        a_outs = use_small ? outs_b : outs_a;
        lowest   = '0;
        in_range = (a < DEPTH * 8);
        if (rst) begin
            model_reset();
            e_resp = '0; e_tag = '0; e_data = '0; e_outs = 0; known = 1'b1;
        end else begin
            known  = ret_tag_at.exists(cyc) ? ret_known_at[cyc] : 1'b1;
            e_tag  = ret_tag_at.exists(cyc) ? ret_tag_at[cyc] : 4'd0;
            e_data = ret_tag_at.exists(cyc) ? ret_data_at[cyc] : 64'd0;
            e_outs = 0;
            for (int t = num_tags; t >= 1; t--) begin
                if (cyc >= free_from[t]) lowest = 4'(t);
                if (accept_at[t] < cyc && cyc < free_from[t]) e_outs++;
            end
            e_resp = '0;
            if (in_range && c == 2'd1) e_resp = lowest;
            else if (in_range && c == 2'd2) e_resp = (lowest != 0) ? lowest : 4'd1;
        end
        check("response", 64'(a_resp), 64'(e_resp));
        check("ret_tag", 64'(a_tag), 64'(e_tag));
        if (known) check("ret_data", a_data, e_data);
        check("outstanding", 64'(a_outs), 64'(e_outs));
        if (!rst) begin
            if (c == 2'd1 && in_range && lowest != 0) begin
                accept_at[lowest] = cyc;
                free_from[lowest] = cyc + LAT + 1;
                wk = model_mem.exists(a >> 3);
                ret_tag_at[cyc + LAT]   = lowest;
                ret_known_at[cyc + LAT] = wk;
                ret_data_at[cyc + LAT]  = wk ? model_mem[a >> 3] : 64'd0;
            end
            if (c == 2'd2 && in_range) model_mem[a >> 3] = d;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 32'd0, 64'd0, 1'b0);
    endtask

    initial begin
        int r;
        logic [1:0]  rc;
        logic [31:0] ra;
        model_reset();
        step(2'd0, 32'd0, 64'd0, 1'b1);
        step(2'd0, 32'd0, 64'd0, 1'b1);
        check("reset_tag", 64'(tag_a), 64'd0);

        // Store then load of the same word, fixed-latency tagged return.
        step(2'd2, 32'h100, 64'hDEADBEEF_CAFEF00D, 1'b0);
        check("t1_store_resp", 64'(resp_a), 64'd1);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t1_load_resp", 64'(resp_a), 64'd1);
        idle(3);
        check("t1_no_early_ret", 64'(tag_a), 64'd0);
        idle(1);
        check("t1_ret_tag", 64'(tag_a), 64'd1);
        check("t1_ret_data", data_a, 64'hDEADBEEF_CAFEF00D);
        idle(1);
        check("t1_ret_once", 64'(tag_a), 64'd0);

        // Back-to-back loads receive increasing tags.
        step(2'd0, 32'd0, 64'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(2'd1, 32'h100, 64'd0, 1'b0);
            check("t2_resp", 64'(resp_a), 64'(i + 1));
        end
        check("t2_outstanding_peak", 64'(outs_a), 64'd4);
        check("t2_first_ret", 64'(tag_a), 64'd1);
        idle(6);

        // Out-of-range load is ignored.
        step(2'd1, 32'h0001_0000, 64'd0, 1'b0);
        check("t3_resp", 64'(resp_a), 64'd0);
        idle(5);
        check("t3_outstanding", 64'(outs_a), 64'd0);

        // Two-tag instance: exhaustion and retry after the freeing edge.
        use_small = 1'b1;
        num_tags  = 2;
        step(2'd0, 32'd0, 64'd0, 1'b1);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t4_resp0", 64'(resp_b), 64'd1);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t4_resp1", 64'(resp_b), 64'd2);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t4_reject", 64'(resp_b), 64'd0);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t4_ret_cycle_reject", 64'(resp_b), 64'd0);
        check("t4_ret_tag", 64'(tag_b), 64'd1);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t4_retry", 64'(resp_b), 64'd1);
        idle(6);
        use_small = 1'b0;
        num_tags  = 15;
        step(2'd0, 32'd0, 64'd0, 1'b1);

        // Reset with a load in flight drops it.
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t5_resp", 64'(resp_a), 64'd1);
        idle(1);
        step(2'd0, 32'd0, 64'd0, 1'b1);
        idle(8);
        step(2'd1, 32'h100, 64'd0, 1'b0);
        check("t5_after_reset_resp", 64'(resp_a), 64'd1);
        idle(1);
        check("t5_outstanding", 64'(outs_a), 64'd1);
        idle(6);

        // Load data is a snapshot taken at acceptance.
        step(2'd2, 32'h8, 64'h1111_2222_3333_4444, 1'b0);
        step(2'd1, 32'h8, 64'd0, 1'b0);
        step(2'd2, 32'h8, 64'h5555_6666_7777_8888, 1'b0);
        idle(3);
        check("t6_snapshot", data_a, 64'h1111_2222_3333_4444);
        idle(2);

        // Randomized traffic over a small word set, including both ends of the address range.
        for (int k = 0; k < 16; k++) begin
            word_addr[k] = (k < 15) ? 32'(k * 8) : 32'(DEPTH * 8 - 8);
            step(2'd2, word_addr[k], {$urandom, $urandom}, 1'b0);
        end
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                step(2'd0, 32'd0, 64'd0, 1'b1);
            end else begin
                r  = int'($urandom_range(0, 99));
                rc = (r < 50) ? 2'd1 : (r < 78) ? 2'd2 : (r < 92) ? 2'd0 : 2'd3;
                r  = int'($urandom_range(0, 99));
                if (r < 4)       ra = 32'(DEPTH * 8);
                else if (r < 8)  ra = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                else if (r < 10) ra = 32'(DEPTH * 8) + $urandom_range(0, 1 << 20);
                else             ra = word_addr[$urandom_range(0, 15)] | 32'($urandom_range(0, 7));
                step(rc, ra, {$urandom, $urandom}, 1'b0);
            end
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
